// File: rtl/polygon_hit_engine.sv
// Point-in-polygon tester: double-buffered vertex banks loaded over a valid/ready
// stream, swapped at frame start, and a fixed 4-stage crossing/winding pixel pipeline.
module polygon_hit_engine #(
  parameter int unsigned PIXEL_WIDTH      = 1280,
  parameter int unsigned PIXEL_HEIGHT     = 720,
  parameter int unsigned MAX_NUM_VERTICES = 8,
  parameter int unsigned NUM_POLYGONS     = 2,
  parameter int unsigned COORD_WIDTH      = 16
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    vtx_valid_in,
  output logic                                    vtx_ready_out,
  input  logic [((NUM_POLYGONS > 1) ? $clog2(NUM_POLYGONS) : 1)-1:0] vtx_poly_in,
  input  logic [$clog2(MAX_NUM_VERTICES):0]       vtx_idx_in,
  input  logic signed [COORD_WIDTH-1:0]           vtx_x_in,
  input  logic signed [COORD_WIDTH-1:0]           vtx_y_in,
  input  logic                                    vtx_last_in,
  input  logic                                    commit_in,
  input  logic                                    frame_start_in,
  output logic                                    load_err_out,
  input  logic                                    pixel_valid_in,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]          hcount_in,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]         vcount_in,
  input  logic                                    fill_mode_in,
  output logic                                    hit_valid_out,
  output logic [NUM_POLYGONS-1:0]                 hit_out
);

  localparam int unsigned NP   = NUM_POLYGONS;
  localparam int unsigned MV   = MAX_NUM_VERTICES;
  localparam int unsigned CW   = COORD_WIDTH;
  localparam int unsigned VIW  = $clog2(MV);
  localparam int unsigned CNTW = VIW + 1;
  localparam int unsigned DW   = CW + 1;
  localparam int unsigned XW   = 2 * CW + 3;
  localparam int unsigned WW   = $clog2(MV) + 2;

  typedef enum logic [1:0] {ST_OPEN, ST_PENDING, ST_SWAP} state_t;

  state_t state_q, state_d;
  logic   swap_c, ready_d;
  logic   beat_c, beat_bad_c;

  logic signed [CW-1:0]   sh_x   [NP][MV];
  logic signed [CW-1:0]   sh_y   [NP][MV];
  logic        [CNTW-1:0] sh_cnt [NP];
  logic signed [CW-1:0]   act_x  [NP][MV];
  logic signed [CW-1:0]   act_y  [NP][MV];
  logic        [CNTW-1:0] act_cnt[NP];

  // State register; ready is registered from the next state
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_OPEN;
      vtx_ready_out <= 1'b1;
    end else begin
      state_q       <= state_d;
      vtx_ready_out <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OPEN:    if (commit_in) state_d = frame_start_in ? ST_SWAP : ST_PENDING;
      ST_PENDING: if (frame_start_in) state_d = ST_SWAP;
      ST_SWAP:    state_d = ST_OPEN;
      default:    state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    swap_c  = 1'b0;
    ready_d = 1'b0;
    swap_c  = (state_q == ST_SWAP);
    ready_d = (state_d == ST_OPEN);
  end

  assign beat_c     = vtx_valid_in & vtx_ready_out;
  assign beat_bad_c = (32'(vtx_idx_in) >= MV) || (32'(vtx_poly_in) >= NP);

  // Shadow bank write port
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int p = 0; p < int'(NP); p++) begin
        sh_cnt[p] <= '0;
        for (int i = 0; i < int'(MV); i++) begin
          sh_x[p][i] <= '0;
          sh_y[p][i] <= '0;
        end
      end
    end else if (beat_c && !beat_bad_c) begin
      sh_x[vtx_poly_in][vtx_idx_in[VIW-1:0]] <= vtx_x_in;
      sh_y[vtx_poly_in][vtx_idx_in[VIW-1:0]] <= vtx_y_in;
      if (vtx_last_in) sh_cnt[vtx_poly_in] <= CNTW'(vtx_idx_in) + CNTW'(1);
    end
  end

  // Active bank: whole-bank copy on swap, shadow left intact
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int p = 0; p < int'(NP); p++) begin
        act_cnt[p] <= '0;
        for (int i = 0; i < int'(MV); i++) begin
          act_x[p][i] <= '0;
          act_y[p][i] <= '0;
        end
      end
    end else if (swap_c) begin
      act_x   <= sh_x;
      act_y   <= sh_y;
      act_cnt <= sh_cnt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                load_err_out <= 1'b0;
    else if (swap_c)              load_err_out <= 1'b0;
    else if (beat_c & beat_bad_c) load_err_out <= 1'b1;
  end

  // Pixel pipeline
  logic                   s1_valid, s2_valid, s3_valid;
  logic                   s1_mode, s2_mode, s3_mode;
  logic signed [CW-1:0]   s1_px, s1_py;
  logic signed [CW-1:0]   s1_x  [NP][MV];
  logic signed [CW-1:0]   s1_y  [NP][MV];
  logic        [CNTW-1:0] s1_cnt[NP];
  logic signed [XW-1:0]   cross_c [NP][MV];
  logic        [MV-1:0]   up_c    [NP];
  logic        [MV-1:0]   dn_c    [NP];
  logic signed [XW-1:0]   s2_cross[NP][MV];
  logic        [MV-1:0]   s2_up   [NP];
  logic        [MV-1:0]   s2_dn   [NP];
  logic signed [1:0]      c_c     [NP][MV];
  logic signed [1:0]      s3_c    [NP][MV];
  logic signed [WW-1:0]   wind_c  [NP];
  logic        [NP-1:0]   hit_c;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s3_valid      <= 1'b0;
      hit_valid_out <= 1'b0;
      hit_out       <= '0;
    end else begin
      s1_valid      <= pixel_valid_in;
      s2_valid      <= s1_valid;
      s3_valid      <= s2_valid;
      hit_valid_out <= s3_valid;
      if (s3_valid) hit_out <= hit_c;
    end
  end

  // Datapath registers carry no reset; validity is tracked by the valid chain
  always_ff @(posedge clk_in) begin
    s1_px    <= CW'(hcount_in);
    s1_py    <= CW'(vcount_in);
    s1_mode  <= fill_mode_in;
    s1_x     <= act_x;
    s1_y     <= act_y;
    s1_cnt   <= act_cnt;
    s2_mode  <= s1_mode;
    s2_cross <= cross_c;
    s2_up    <= up_c;
    s2_dn    <= dn_c;
    s3_mode  <= s2_mode;
    s3_c     <= c_c;
  end

  // S2: per-edge cross product and half-open crossing flags, masked by count
  always_comb begin
    logic [VIW-1:0]       j;
    logic signed [CW-1:0] xi, yi, xj, yj;
    logic signed [DW-1:0] ex, ey, dpx, dpy;
    logic                 en;
    j = '0; xi = '0; yi = '0; xj = '0; yj = '0;
    ex = '0; ey = '0; dpx = '0; dpy = '0; en = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin
      up_c[p] = '0;
      dn_c[p] = '0;
      for (int i = 0; i < int'(MV); i++) begin
        j   = (CNTW'(i + 1) == s1_cnt[p]) ? '0 : VIW'(i + 1);
        xi  = s1_x[p][i];
        yi  = s1_y[p][i];
        xj  = s1_x[p][j];
        yj  = s1_y[p][j];
        ex  = DW'(xj) - DW'(xi);
        ey  = DW'(yj) - DW'(yi);
        dpx = DW'(s1_px) - DW'(xi);
        dpy = DW'(s1_py) - DW'(yi);
        cross_c[p][i] = XW'(ex) * XW'(dpy) - XW'(dpx) * XW'(ey);
        en         = (CNTW'(i) < s1_cnt[p]) && (s1_cnt[p] >= CNTW'(3));
        up_c[p][i] = en && (yi <= s1_py) && (yj > s1_py);
        dn_c[p][i] = en && (yi > s1_py) && (yj <= s1_py);
      end
    end
  end

  // S3: signed crossing contribution
  always_comb begin
    for (int p = 0; p < int'(NP); p++) begin
      for (int i = 0; i < int'(MV); i++) begin
        c_c[p][i] = 2'sb00;
        if (s2_up[p][i] && !s2_cross[p][i][XW-1] && (|s2_cross[p][i]))
          c_c[p][i] = 2'sb01;
        else if (s2_dn[p][i] && s2_cross[p][i][XW-1])
          c_c[p][i] = 2'sb11;
      end
    end
  end

  // S4: winding sum and fill-rule decision
  always_comb begin
    hit_c = '0;
    for (int p = 0; p < int'(NP); p++) begin
      wind_c[p] = '0;
      for (int i = 0; i < int'(MV); i++) wind_c[p] = wind_c[p] + WW'(s3_c[p][i]);
      hit_c[p] = s3_mode ? (|wind_c[p]) : wind_c[p][0];
    end
  end

endmodule

// File: tb/tb_polygon_hit_engine.sv
// Scoreboard bench for polygon_hit_engine: a reference crossing/winding model
// predicts each pixel's hit vector, compared when hit_valid_out appears.
module tb_polygon_hit_engine;

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               vtx_valid_in, vtx_ready_out, vtx_last_in;
  logic [0:0]         vtx_poly_in;
  logic [3:0]         vtx_idx_in;
  logic signed [15:0] vtx_x_in, vtx_y_in;
  logic               commit_in, frame_start_in, load_err_out;
  logic               pixel_valid_in, fill_mode_in, hit_valid_out;
  logic [10:0]        hcount_in;
  logic [9:0]         vcount_in;
  logic [1:0]         hit_out;

  polygon_hit_engine dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .vtx_valid_in(vtx_valid_in), .vtx_ready_out(vtx_ready_out),
    .vtx_poly_in(vtx_poly_in), .vtx_idx_in(vtx_idx_in),
    .vtx_x_in(vtx_x_in), .vtx_y_in(vtx_y_in), .vtx_last_in(vtx_last_in),
    .commit_in(commit_in), .frame_start_in(frame_start_in), .load_err_out(load_err_out),
    .pixel_valid_in(pixel_valid_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .fill_mode_in(fill_mode_in), .hit_valid_out(hit_valid_out), .hit_out(hit_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int sx[2][8], sy[2][8], scnt[2];
  int ax[2][8], ay[2][8], acnt[2];
  logic [1:0] q_exp[$];
  int         q_cyc[$];
  logic [1:0] last_exp = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_hit(input int p, input int px, input int py, input logic m);
    int n, w, j;
    longint cr;
    n = acnt[p];
    w = 0;
    if (n < 3) return 1'b0;
    for (int i = 0; i < n; i++) begin
      j  = (i + 1) % n;
      cr = longint'(ax[p][j] - ax[p][i]) * longint'(py - ay[p][i])
         - longint'(px - ax[p][i]) * longint'(ay[p][j] - ay[p][i]);
      if (ay[p][i] <= py && ay[p][j] > py && cr > 0) w++;
      else if (ay[p][i] > py && ay[p][j] <= py && cr < 0) w--;
    end
    return m ? (w != 0) : ((w & 1) != 0);
  endfunction

  // Scoreboard checker
  always @(negedge clk_in) begin
    if (rst_n_in && hit_valid_out) begin
      if (q_exp.size() == 0) begin
        check("spurious_valid", 32'(hit_valid_out), 32'd0);
      end else begin
        last_exp = q_exp.pop_front();
        check("hit", 32'(hit_out), 32'(last_exp));
        check("latency", 32'(cyc - q_cyc.pop_front()), 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic send_beat(input int p, input int idx, input int x, input int y, input bit last);
    int n = 0;
    vtx_valid_in = 1'b1; vtx_poly_in = 1'(p); vtx_idx_in = 4'(idx);
    vtx_x_in = 16'(x); vtx_y_in = 16'(y); vtx_last_in = last;
    while (!vtx_ready_out && n < 50) begin tick(); n++; end
    check("beat_ready", 32'(vtx_ready_out), 32'd1);
    tick();
    vtx_valid_in = 1'b0; vtx_last_in = 1'b0;
    if (idx < 8) begin
      sx[p][idx] = x; sy[p][idx] = y;
      if (last) scnt[p] = idx + 1;
    end
  endtask

  task automatic bank_to_active();
    ax = sx; ay = sy; acnt = scnt;
  endtask

  task automatic do_swap();
    commit_in = 1'b1; tick(); commit_in = 1'b0;
    check("pend_ready", 32'(vtx_ready_out), 32'd0);
    frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
    check("swap_ready", 32'(vtx_ready_out), 32'd0);
    tick();
    check("open_ready", 32'(vtx_ready_out), 32'd1);
    check("err_clear", 32'(load_err_out), 32'd0);
    bank_to_active();
  endtask

  task automatic pix(input int x, input int y, input logic m);
    q_exp.push_back({model_hit(1, x, y, m), model_hit(0, x, y, m)});
    q_cyc.push_back(cyc);
    pixel_valid_in = 1'b1; hcount_in = 11'(x); vcount_in = 10'(y); fill_mode_in = m;
    tick();
    pixel_valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 20) begin tick(); n++; end
    check("drain", 32'(q_exp.size()), 32'd0);
    repeat (3) tick();
    check("hold", 32'(hit_out), 32'(last_exp));
  endtask

  task automatic random_pixels(input int num);
    for (int k = 0; k < num; k++)
      pix(int'($urandom_range(430, 80)), int'($urandom_range(430, 80)), 1'($urandom_range(1, 0)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in = 1'b0; vtx_valid_in = 1'b0; vtx_poly_in = '0; vtx_idx_in = '0;
    vtx_x_in = '0; vtx_y_in = '0; vtx_last_in = 1'b0; commit_in = 1'b0;
    frame_start_in = 1'b0; pixel_valid_in = 1'b0; hcount_in = '0; vcount_in = '0;
    fill_mode_in = 1'b0;
    for (int p = 0; p < 2; p++) begin
      scnt[p] = 0;
      for (int i = 0; i < 8; i++) begin sx[p][i] = 0; sy[p][i] = 0; end
    end
    bank_to_active();
    #12;
    check("rst_hit_valid", 32'(hit_valid_out), 32'd0);
    check("rst_hit", 32'(hit_out), 32'd0);
    check("rst_err", 32'(load_err_out), 32'd0);
    check("rst_ready", 32'(vtx_ready_out), 32'd1);
    #10 rst_n_in = 1'b1;
    tick();

    // Square in polygon 0
    send_beat(0, 0, 100, 100, 1'b0);
    send_beat(0, 1, 200, 100, 1'b0);
    send_beat(0, 2, 200, 200, 1'b0);
    send_beat(0, 3, 100, 200, 1'b1);
    do_swap();
    pix(150, 150, 1'b0);
    pix(250, 150, 1'b0);
    pix(99, 150, 1'b0);
    pix(150, 100, 1'b0);
    pix(150, 150, 1'b1);
    drain();
    check("square_edge_hit", 32'(hit_out), 32'd1);

    // Pentagram into polygon 1 while a commit is pending
    commit_in = 1'b1; tick(); commit_in = 1'b0;
    vtx_valid_in = 1'b1; vtx_poly_in = 1'b1; vtx_idx_in = 4'd0;
    vtx_x_in = 16'sd300; vtx_y_in = 16'sd200; vtx_last_in = 1'b0;
    repeat (3) begin check("pend_hold_ready", 32'(vtx_ready_out), 32'd0); tick(); end
    frame_start_in = 1'b1; tick(); frame_start_in = 1'b0;
    check("swap_ready", 32'(vtx_ready_out), 32'd0);
    bank_to_active();
    tick();
    check("open_ready", 32'(vtx_ready_out), 32'd1);
    tick();
    vtx_valid_in = 1'b0;
    sx[1][0] = 300; sy[1][0] = 200;
    send_beat(1, 1, 359, 381, 1'b0);
    send_beat(1, 2, 205, 269, 1'b0);
    send_beat(1, 8, 999, 999, 1'b1);
    check("load_err_set", 32'(load_err_out), 32'd1);
    send_beat(1, 3, 395, 269, 1'b0);
    send_beat(1, 4, 241, 381, 1'b1);
    do_swap();
    pix(300, 300, 1'b0);
    pix(300, 300, 1'b1);
    drain();
    check("star_nonzero", 32'(hit_out), 32'd2);
    random_pixels(40);
    drain();

    // Partial reload: triangle over the square, degenerate 2-vertex polygon 1
    send_beat(0, 0, 120, 120, 1'b0);
    send_beat(0, 1, 380, 160, 1'b0);
    send_beat(0, 2, 200, 400, 1'b1);
    send_beat(1, 0, 150, 150, 1'b0);
    send_beat(1, 1, 400, 400, 1'b1);
    do_swap();
    pix(230, 230, 1'b0);
    random_pixels(40);
    drain();

    // Reset mid-stream with an error flagged and pixels in flight
    send_beat(0, 9, 0, 0, 1'b0);
    check("load_err_set2", 32'(load_err_out), 32'd1);
    send_beat(0, 0, 100, 100, 1'b0);
    send_beat(0, 1, 300, 100, 1'b0);
    send_beat(0, 2, 200, 300, 1'b1);
    pix(200, 150, 1'b0);
    pix(200, 160, 1'b1);
    pix(210, 170, 1'b0);
    pixel_valid_in = 1'b1;
    #3 rst_n_in = 1'b0;
    #1;
    check("mid_rst_hit_valid", 32'(hit_valid_out), 32'd0);
    check("mid_rst_err", 32'(load_err_out), 32'd0);
    check("mid_rst_hit", 32'(hit_out), 32'd0);
    q_exp.delete(); q_cyc.delete(); last_exp = 2'b00;
    for (int p = 0; p < 2; p++) begin
      scnt[p] = 0;
      for (int i = 0; i < 8; i++) begin sx[p][i] = 0; sy[p][i] = 0; end
    end
    bank_to_active();
    #20 pixel_valid_in = 1'b0;
    #3 rst_n_in = 1'b1;
    tick();
    check("post_rst_ready", 32'(vtx_ready_out), 32'd1);
    pix(200, 150, 1'b0);
    drain();
    do_swap();
    pix(200, 150, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
